ham_deco: RTL and testbench
===========================

Name: ham_deco

Overview:
- Pipelined single-error-correcting Hamming decoder, the receive-side counterpart of the 8-bit/12-bit even-parity Hamming encoder.
- Takes 12-bit codewords read back from dual-port RAM storage. Returns corrected 8-bit data with error flags.
- Keeps saturating error-statistics counters for software scrubbing and monitoring.

Parameters:
- CNT_W, 16, width of the corrected-error and uncorrectable-error counters (2..32).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  codeword on i_code is valid this cycle.
- i_code  in  12  codeword. Bit index k holds Hamming position k+1: p0=[0], p1=[1], d0=[2], p2=[3], d1..d3=[6:4], p3=[7], d4..d7=[11:8].
- i_cnt_clr  in  1  synchronous clear of both counters.
- o_valid  out  1  o_data and flags valid.
- o_data  out  8  decoded (corrected when possible) data.
- o_syndrome  out  4  syndrome of the codeword now on o_data.
- o_err_corr  out  1  single-bit error detected and corrected (data or parity bit).
- o_err_uncorr  out  1  syndrome 13..15; data not correctable.
- o_corr_cnt  out  CNT_W  count of o_err_corr events.
- o_uncorr_cnt  out  CNT_W  count of o_err_uncorr events.

Behaviour:
- Reset (i_rst_n low, asynchronous, any time): all outputs and pipeline registers are 0. This includes o_valid, o_data, o_syndrome, both flags and both counters. In-flight codewords are discarded; no partial output after release.
- No back-pressure. Pipeline accepts one codeword per cycle, continuously.

Stage 1, registered on the edge where i_valid=1:
- Stage-1 registers capture the codeword, the valid bit and syndrome s[3:0], all even parity over Hamming positions:
  - s0 = XOR of positions 1,3,5,7,9,11
  - s1 = XOR of positions 2,3,6,7,10,11
  - s2 = XOR of positions 4,5,6,7,12
  - s3 = XOR of positions 8,9,10,11,12
- The valid bit is registered every cycle, so i_valid=0 yields an invalid bubble.

Stage 2, output registers:
- s=0: o_data = extracted data; both flags 0.
- s=1..12: invert codeword bit index s-1, then extract data; o_err_corr=1. A parity-position error (s=1,2,4,8) leaves the data unchanged but still sets o_err_corr.
- s=13..15: no correction; o_data = raw extracted data; o_err_uncorr=1.
- Latency: exactly 2 cycles from the i_valid edge to o_valid=1.
- o_valid=0 cycles: o_data and o_syndrome hold their last values; flags forced to 0.

Counters:
- Increment on the same edge that registers the corresponding flag=1.
- Saturate at all-ones; no wrap.
- i_cnt_clr=1: both counters become 0 on that edge. Clear wins over a simultaneous increment, and that event is not counted.
- Double errors that alias to a syndrome of 1..12 are miscorrected and counted as corrected. This is accepted SEC behaviour, not flagged.

Test Plan:
- Clean data: i_code=12'h186 with i_valid for 1 cycle -> 2 cycles later o_valid=1, o_data=8'h11, o_syndrome=0, both flags 0, counters 0.
- Data-bit error: i_code=12'h196 (bit 4 flipped) -> o_data=8'h11, o_syndrome=5, o_err_corr=1, o_corr_cnt=1.
- Parity-bit error: i_code=12'h118 (p3 flipped in 12'h198) -> o_data=8'h12, o_syndrome=8, o_err_corr=1.
- Uncorrectable: i_code=12'h0A6 (bits 5 and 8 flipped in 12'h186) -> o_syndrome=15, o_err_uncorr=1, o_data=8'h05, o_uncorr_cnt=1.
- Streaming and counters:
  - Sequence 12'h186, 12'h196, 12'h198 on three consecutive cycles -> outputs 8'h11, 8'h11, 8'h12 on consecutive cycles.
  - Set CNT_W=2 and drive 5 correctable codewords -> o_corr_cnt saturates at 3.
  - Assert i_cnt_clr on a correctable cycle -> counter reads 0.
- Reset mid-operation: drop i_rst_n one cycle after issuing 12'h196 -> o_valid, flags and counters go 0 immediately. No output appears after release until a new i_valid.

Source files
------------

// File: rtl/ham_deco_if.sv
// Codeword-in / decoded-word-out bundle for the Hamming decoder.
// Error counters are kept outside the bundle so that CNT_W stays a parameter of the decoder alone.
interface ham_deco_if;
    logic        i_valid;
    logic [11:0] i_code;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [3:0]  o_syndrome;
    logic        o_err_corr;
    logic        o_err_uncorr;

    modport master (
        output i_valid, i_code,
        input  o_valid, o_data, o_syndrome, o_err_corr, o_err_uncorr
    );

    modport slave (
        input  i_valid, i_code,
        output o_valid, o_data, o_syndrome, o_err_corr, o_err_uncorr
    );
endinterface

// File: rtl/ham_deco.sv
// Two-stage SEC Hamming decoder for 12-bit codewords carrying 8 data bits.
// It keeps saturating counters of corrected and uncorrectable events.
module ham_deco #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cnt_clr,
    ham_deco_if.slave        bus,
    output logic [CNT_W-1:0] o_corr_cnt,
    output logic [CNT_W-1:0] o_uncorr_cnt
);

    logic             valid1_q, valid1_d;
    logic [11:0]      code1_q, code1_d;
    logic [3:0]       syn1_q, syn1_d;
    logic             valid2_q, valid2_d;
    logic [7:0]       data2_q, data2_d;
    logic [3:0]       syn2_q, syn2_d;
    logic             corr2_q, corr2_d;
    logic             uncorr2_q, uncorr2_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic [11:0]      fixed;
    logic [3:0]       syn_in;

    always_comb begin
        syn_in[0] = bus.i_code[0] ^ bus.i_code[2] ^ bus.i_code[4] ^ bus.i_code[6]
                  ^ bus.i_code[8] ^ bus.i_code[10];
        syn_in[1] = bus.i_code[1] ^ bus.i_code[2] ^ bus.i_code[5] ^ bus.i_code[6]
                  ^ bus.i_code[9] ^ bus.i_code[10];
        syn_in[2] = bus.i_code[3] ^ bus.i_code[4] ^ bus.i_code[5] ^ bus.i_code[6]
                  ^ bus.i_code[11];
        syn_in[3] = bus.i_code[7] ^ bus.i_code[8] ^ bus.i_code[9] ^ bus.i_code[10]
                  ^ bus.i_code[11];

        valid1_d = bus.i_valid;
        code1_d  = bus.i_valid ? bus.i_code : code1_q;
        syn1_d   = bus.i_valid ? syn_in : syn1_q;
    end

    // Syndrome 1..12 names the flipped bit position; 13..15 cannot come from a single error.
    always_comb begin
        fixed = code1_q;
        for (int k = 0; k < 12; k++) begin
            if (syn1_q == 4'(k + 1)) fixed[k] = ~code1_q[k];
        end

        valid2_d  = valid1_q;
        data2_d   = data2_q;
        syn2_d    = syn2_q;
        corr2_d   = 1'b0;
        uncorr2_d = 1'b0;
        if (valid1_q) begin
            syn2_d = syn1_q;
            if (syn1_q >= 4'd13) begin
                uncorr2_d = 1'b1;
                data2_d   = {code1_q[11:8], code1_q[6:4], code1_q[2]};
            end else begin
                corr2_d = (syn1_q != 4'd0);
                data2_d = {fixed[11:8], fixed[6:4], fixed[2]};
            end
        end
    end

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (i_cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (corr2_d && !(&corr_cnt_q))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
            if (uncorr2_d && !(&uncorr_cnt_q)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid1_q     <= 1'b0;
            code1_q      <= '0;
            syn1_q       <= '0;
            valid2_q     <= 1'b0;
            data2_q      <= '0;
            syn2_q       <= '0;
            corr2_q      <= 1'b0;
            uncorr2_q    <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            valid1_q     <= valid1_d;
            code1_q      <= code1_d;
            syn1_q       <= syn1_d;
            valid2_q     <= valid2_d;
            data2_q      <= data2_d;
            syn2_q       <= syn2_d;
            corr2_q      <= corr2_d;
            uncorr2_q    <= uncorr2_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.o_valid      = valid2_q;
    assign bus.o_data       = data2_q;
    assign bus.o_syndrome   = syn2_q;
    assign bus.o_err_corr   = corr2_q;
    assign bus.o_err_uncorr = uncorr2_q;
    assign o_corr_cnt       = corr_cnt_q;
    assign o_uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_ham_deco.sv
// Directed bench for ham_deco: a 16-bit-counter instance for decode behaviour
// and a 2-bit-counter instance for saturation.
module tb_ham_deco;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        clr2 = 1'b0;
    logic [15:0] ccnt, ucnt;
    logic [1:0]  ccnt2, ucnt2;
    int          n_total = 0;
    int          n_pass = 0;

    ham_deco_if bus ();
    ham_deco_if bus2 ();

    ham_deco #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cnt_clr(clr), .bus(bus),
        .o_corr_cnt(ccnt), .o_uncorr_cnt(ucnt)
    );

    ham_deco #(.CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cnt_clr(clr2), .bus(bus2),
        .o_corr_cnt(ccnt2), .o_uncorr_cnt(ucnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [11:0] c);
        bus.i_valid = v;
        bus.i_code  = c;
    endtask

    // One codeword, idle afterwards; returns at the negedge where its result is on the outputs.
    task automatic send_one(input logic [11:0] c);
        drive(1'b1, c);
        tick();
        drive(1'b0, 12'h000);
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [3:0] s,
                           input logic ec, input logic eu);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
        chk({tag, ".data"}, 32'(bus.o_data), 32'(d));
        chk({tag, ".syn"}, 32'(bus.o_syndrome), 32'(s));
        chk({tag, ".corr"}, 32'(bus.o_err_corr), 32'(ec));
        chk({tag, ".uncorr"}, 32'(bus.o_err_uncorr), 32'(eu));
    endtask

    initial begin
        drive(1'b0, 12'h000);
        bus2.i_valid = 1'b0;
        bus2.i_code  = 12'h000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", 32'(bus.o_valid), 32'd0);
        chk("rst.data", 32'(bus.o_data), 32'd0);
        chk("rst.syn", 32'(bus.o_syndrome), 32'd0);
        chk("rst.flags", 32'({bus.o_err_corr, bus.o_err_uncorr}), 32'd0);
        chk("rst.cnt", 32'({ccnt, ucnt}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // clean codeword, with latency check on the intermediate cycle
        drive(1'b1, 12'h186);
        tick();
        drive(1'b0, 12'h000);
        chk("lat.valid1", 32'(bus.o_valid), 32'd0);
        tick();
        chk_out("clean", 8'h11, 4'd0, 1'b0, 1'b0);
        chk("clean.ccnt", 32'(ccnt), 32'd0);
        chk("clean.ucnt", 32'(ucnt), 32'd0);
        tick();
        chk("bubble.valid", 32'(bus.o_valid), 32'd0);
        chk("bubble.hold", 32'(bus.o_data), 32'h11);
        chk("bubble.syn", 32'(bus.o_syndrome), 32'd0);

        send_one(12'h196);
        chk_out("dataerr", 8'h11, 4'd5, 1'b1, 1'b0);
        chk("dataerr.ccnt", 32'(ccnt), 32'd1);
        tick();
        chk("dataerr.flagdrop", 32'(bus.o_err_corr), 32'd0);
        chk("dataerr.synhold", 32'(bus.o_syndrome), 32'd5);

        send_one(12'h118);
        chk_out("parerr", 8'h12, 4'd8, 1'b1, 1'b0);
        chk("parerr.ccnt", 32'(ccnt), 32'd2);

        send_one(12'h0A6);
        chk_out("uncorr", 8'h05, 4'd15, 1'b0, 1'b1);
        chk("uncorr.ucnt", 32'(ucnt), 32'd1);
        chk("uncorr.ccnt", 32'(ccnt), 32'd2);

        // back-to-back stream
        drive(1'b1, 12'h186);
        tick();
        drive(1'b1, 12'h196);
        tick();
        chk_out("strm0", 8'h11, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 12'h198);
        tick();
        chk_out("strm1", 8'h11, 4'd5, 1'b1, 1'b0);
        drive(1'b0, 12'h000);
        tick();
        chk_out("strm2", 8'h12, 4'd0, 1'b0, 1'b0);
        chk("strm.ccnt", 32'(ccnt), 32'd3);

        // clear on the same edge as a correctable event
        clr = 1'b1;
        send_one(12'h196);
        chk("clr.flag", 32'(bus.o_err_corr), 32'd1);
        chk("clr.ccnt", 32'(ccnt), 32'd0);
        chk("clr.ucnt", 32'(ucnt), 32'd0);
        clr = 1'b0;
        send_one(12'h196);
        chk("postclr.ccnt", 32'(ccnt), 32'd1);

        // saturation on the 2-bit instance: five correctable codewords back to back
        chk("sat.start", 32'(ccnt2), 32'd0);
        bus2.i_valid = 1'b1;
        bus2.i_code  = 12'h196;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 4) bus2.i_valid = 1'b0;
            if (i >= 1) chk($sformatf("sat.ccnt%0d", i), 32'(ccnt2), 32'(i > 3 ? 3 : i));
        end
        chk("sat.ucnt", 32'(ucnt2), 32'd0);

        // reset while a codeword is in flight and another is on the outputs
        drive(1'b1, 12'h196);
        tick();
        drive(1'b1, 12'h196);
        tick();
        drive(1'b0, 12'h000);
        chk("prerst.valid", 32'(bus.o_valid), 32'd1);
        chk("prerst.ccnt", 32'(ccnt), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(bus.o_valid), 32'd0);
        chk("midrst.flags", 32'({bus.o_err_corr, bus.o_err_uncorr}), 32'd0);
        chk("midrst.ccnt", 32'(ccnt), 32'd0);
        chk("midrst.data", 32'(bus.o_data), 32'd0);
        chk("midrst.ccnt2", 32'(ccnt2), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst.valid%0d", i), 32'(bus.o_valid), 32'd0);
        end
        send_one(12'h198);
        chk_out("postrst", 8'h12, 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
